dlx_decode_stage: RTL and testbench
===================================

DLX_DECODE_STAGE -- requirements
Module: dlx_decode_stage

Interface
REQ-001 Parameter XLEN, 32, datapath and register width in bits.
REQ-002 Parameter NREG, 32, register count; R0 is hard-wired to zero; AW = clog2(NREG) is derived.
REQ-003 clock2  in  1  clock; all state updates on the rising edge.
REQ-004 reset2  in  1  reset, asynchronous, active-low.
REQ-005 inst_in2  in  32  instruction from fetch.
REQ-006 npc_in2  in  XLEN  next-PC from fetch.
REQ-007 in_valid  in  1  fetch offers inst_in2/npc_in2.
REQ-008 in_ready  out  1  stage accepts this cycle.
REQ-009 reg_write_en  in  1  write-back strobe.
REQ-010 reg_add_in  in  AW  write-back register address.
REQ-011 reg_data_in  in  XLEN  write-back data.
REQ-012 ex_load_valid  in  1  execute stage holds a load.
REQ-013 ex_load_rd  in  AW  destination register of that load.
REQ-014 ex_ready  in  1  execute stage accepts this cycle.
REQ-015 out_valid  out  1  decoded bundle valid.
REQ-016 irout2, npcout2  out  32, XLEN  registered instruction and NPC.
REQ-017 aout2, bout2, imout2  out  XLEN each  operand A, operand B, extended immediate.
REQ-018 out_illegal  out  1  opcode or R-type func code not recognised.
REQ-019 dbg_rd_addr  in  AW; dbg_rd_data  out  XLEN  combinational register-file observation port.

Function
REQ-020 Field layout: opcode [31:26], rs1 [25:21], rd_rs2 [20:16], imm16 [15:0], offset [25:0], func [5:0]. Register fields are truncated to AW bits.
REQ-021 Operands use two's complement throughout. No sign-magnitude conversion anywhere.
REQ-022 imout2 is set as follows:
- Sign-extend imm16 for LW, SW, ADDI, SUBI, SLTI..SNEI, BEQZ, BNEZ.
- Zero-extend imm16 for ANDI, ORI, XORI.
- Sign-extend offset for J.
- 0 for R_TYPE.
REQ-023 aout2 = value of rs1 for all opcodes except J, where it is 0.
REQ-024 bout2 = value of rd_rs2 for SW and R_TYPE, else 0.
REQ-025 Any read of R0 returns 0.
REQ-026 Write-through bypass: if reg_write_en, reg_add_in != 0 and reg_add_in equals a read address in the same cycle, the read returns reg_data_in.
REQ-027 Writes to R0 are discarded.
REQ-028 Load-use hazard = in_valid & ex_load_valid & ex_load_rd != 0 & ex_load_rd matches a source register the opcode actually reads (rs1, and rd_rs2 when REQ-024 applies).
REQ-029 in_ready = (~out_valid | ex_ready) & ~hazard.
REQ-030 Fire = in_valid & in_ready. On fire, the output bundle registers decoded values and out_valid <= 1 (latency 1 cycle).
REQ-031 When (~out_valid | ex_ready) and no fire, out_valid <= 0. During a hazard this inserts a bubble.
REQ-032 While out_valid & ~ex_ready, all outputs hold stable.
REQ-033 out_illegal asserts in either case:
- opcode is not in the package opcode table;
- opcode is R_TYPE and func is not in {ADD, SUB, AND, OR, XOR, SLT, SGT, SLE, SGE, SEQ, SNE}.
An illegal instruction still propagates, with A/B/imm = 0.
REQ-034 Register-file writes occur every cycle they are enabled, independent of stall or handshake state.

Reset
REQ-035 On reset2 low, asynchronously clear all registers and all outputs to 0. This includes out_valid = 0 and out_illegal = 0.
REQ-036 in_ready is 1 after reset, because out_valid = 0 and no hazard is present.
REQ-037 Reset asserted mid-stall discards the held bundle. No write-back is lost except one coincident with the reset edge.

Structure
REQ-038 Package dlx_pkg holds:
- opcode constants LW=6'b000010, SW, ADDI, SUBI, ANDI, ORI, XORI, SLTI..SNEI, BEQZ, BNEZ, J, R_TYPE;
- func constants;
- the decoded-bundle struct type.
REQ-039 Sub-module dlx_regfile provides a parametrised 2-read/1-write register file with bypass, plus the debug read port.

Verification
REQ-040 Write R3=32'hFFFF_FFF6 via write-back, then issue ADDI rs1=3, imm=16'hFFFE -> next cycle aout2=32'hFFFF_FFF6, imout2=32'hFFFF_FFFE, out_valid=1.
REQ-041 In the same cycle, issue write R5=32'h1234 and R_TYPE ADD rs1=5, rs2=0 -> aout2=32'h1234 (bypass), bout2=0.
REQ-042 Set ex_load_valid=1, ex_load_rd=7, and present SW rs1=7 -> in_ready=0, out_valid=0 bubble next cycle. Clear ex_load_valid -> SW accepted one cycle later.
REQ-043 Hold ex_ready=0 with out_valid=1 for 3 cycles while new instructions are offered -> outputs unchanged, in_ready=0. Release -> the next instruction lands in 1 cycle.
REQ-044 Issue ORI imm=16'h8001 -> imout2=32'h0000_8001. Issue J offset=26'h3FFFFFC -> imout2=32'hFFFF_FFFC.
REQ-045 Issue opcode 6'b111111 -> out_illegal=1. Pulse reset2 low mid-stall -> all outputs 0 immediately and dbg_rd_data=0 for every address.

Source files
------------

// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - DLX opcode/func tables and the decode-control bundle
package dlx_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_LW     = 6'b000010;
  localparam logic [5:0] OP_SW     = 6'h03;
  localparam logic [5:0] OP_ADDI   = 6'h04;
  localparam logic [5:0] OP_SUBI   = 6'h05;
  localparam logic [5:0] OP_ANDI   = 6'h06;
  localparam logic [5:0] OP_ORI    = 6'h07;
  localparam logic [5:0] OP_XORI   = 6'h08;
  localparam logic [5:0] OP_SLTI   = 6'h09;
  localparam logic [5:0] OP_SGTI   = 6'h0A;
  localparam logic [5:0] OP_SLEI   = 6'h0B;
  localparam logic [5:0] OP_SGEI   = 6'h0C;
  localparam logic [5:0] OP_SEQI   = 6'h0D;
  localparam logic [5:0] OP_SNEI   = 6'h0E;
  localparam logic [5:0] OP_BEQZ   = 6'h0F;
  localparam logic [5:0] OP_BNEZ   = 6'h10;
  localparam logic [5:0] OP_J      = 6'h11;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SEQ = 6'h28;
  localparam logic [5:0] FN_SNE = 6'h29;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SGT = 6'h2B;
  localparam logic [5:0] FN_SLE = 6'h2C;
  localparam logic [5:0] FN_SGE = 6'h2D;

  typedef enum logic [1:0] {IMM_NONE, IMM_SEXT16, IMM_ZEXT16, IMM_SEXT26} imm_kind_e;

  typedef struct packed {
    logic      illegal;
    logic      use_a;
    logic      use_b;
    imm_kind_e imm_kind;
  } decode_t;

  // Illegal instructions read no registers, so they can never raise a load-use stall.
  function automatic decode_t dlx_decode(input logic [5:0] opcode, input logic [5:0] func);
    decode_t d;
    d = '{illegal: 1'b0, use_a: 1'b1, use_b: 1'b0, imm_kind: IMM_NONE};
    case (opcode)
      OP_LW, OP_ADDI, OP_SUBI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI,
      OP_SEQI, OP_SNEI, OP_BEQZ, OP_BNEZ: d.imm_kind = IMM_SEXT16;
      OP_SW: begin
        d.imm_kind = IMM_SEXT16;
        d.use_b    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: d.imm_kind = IMM_ZEXT16;
      OP_J: begin
        d.imm_kind = IMM_SEXT26;
        d.use_a    = 1'b0;
      end
      OP_R_TYPE: begin
        d.use_b = 1'b1;
        case (func)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT,
          FN_SGT, FN_SLE, FN_SGE, FN_SEQ, FN_SNE: d.illegal = 1'b0;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.use_a    = 1'b0;
      d.use_b    = 1'b0;
      d.imm_kind = IMM_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/dlx_regfile.sv
// rtl/dlx_regfile.sv - 2-read/1-write register file with write-through bypass and debug port
module dlx_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clock2,
  input  logic            reset2,
  input  logic            write_en,
  input  logic [AW-1:0]   write_addr,
  input  logic [XLEN-1:0] write_data,
  input  logic [AW-1:0]   ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clock2 or negedge reset2) begin
    if (!reset2) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (write_en && write_addr != '0) begin
      regs[write_addr] <= write_data;
    end
  end

  // A same-cycle write to the read address wins, so decode sees the value write-back is committing.
  always_comb begin
    ra_data = regs[ra_addr];
    if (ra_addr == '0) ra_data = '0;
    else if (write_en && write_addr == ra_addr) ra_data = write_data;

    rb_data = regs[rb_addr];
    if (rb_addr == '0) rb_data = '0;
    else if (write_en && write_addr == rb_addr) rb_data = write_data;

    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

endmodule

// File: rtl/dlx_decode_stage.sv
// rtl/dlx_decode_stage.sv - DLX decode stage: operand fetch, immediate extension, load-use stall
module dlx_decode_stage
  import dlx_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clock2,
  input  logic            reset2,
  input  logic [31:0]     inst_in2,
  input  logic [XLEN-1:0] npc_in2,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            reg_write_en,
  input  logic [AW-1:0]   reg_add_in,
  input  logic [XLEN-1:0] reg_data_in,
  input  logic            ex_load_valid,
  input  logic [AW-1:0]   ex_load_rd,
  input  logic            ex_ready,
  output logic            out_valid,
  output logic [31:0]     irout2,
  output logic [XLEN-1:0] npcout2,
  output logic [XLEN-1:0] aout2,
  output logic [XLEN-1:0] bout2,
  output logic [XLEN-1:0] imout2,
  output logic            out_illegal,
  input  logic [AW-1:0]   dbg_rd_addr,
  output logic [XLEN-1:0] dbg_rd_data
);

  logic [AW-1:0]   rs1, rs2;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] a_next, b_next, imm_next;
  decode_t         dec;
  logic            hazard, advance, fire;

  assign rs1 = AW'(inst_in2[25:21]);
  assign rs2 = AW'(inst_in2[20:16]);
  assign dec = dlx_decode(inst_in2[31:26], inst_in2[5:0]);

  dlx_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_regfile (
    .clock2     (clock2),
    .reset2     (reset2),
    .write_en   (reg_write_en),
    .write_addr (reg_add_in),
    .write_data (reg_data_in),
    .ra_addr    (rs1),
    .ra_data    (rs1_data),
    .rb_addr    (rs2),
    .rb_data    (rs2_data),
    .dbg_addr   (dbg_rd_addr),
    .dbg_data   (dbg_rd_data)
  );

  always_comb begin
    a_next = dec.use_a ? rs1_data : '0;
    b_next = dec.use_b ? rs2_data : '0;
    case (dec.imm_kind)
      IMM_SEXT16: imm_next = {{(XLEN-16){inst_in2[15]}}, inst_in2[15:0]};
      IMM_ZEXT16: imm_next = {{(XLEN-16){1'b0}}, inst_in2[15:0]};
      IMM_SEXT26: imm_next = {{(XLEN-26){inst_in2[25]}}, inst_in2[25:0]};
      default:    imm_next = '0;
    endcase
  end

  assign hazard = in_valid && ex_load_valid && (ex_load_rd != '0) &&
                  ((dec.use_a && ex_load_rd == rs1) || (dec.use_b && ex_load_rd == rs2));
  assign advance  = !out_valid || ex_ready;
  assign in_ready = advance && !hazard;
  assign fire     = in_valid && in_ready;

  // Data registers only move on fire; a bubble just drops out_valid.
  always_ff @(posedge clock2 or negedge reset2) begin
    if (!reset2) begin
      out_valid   <= 1'b0;
      irout2      <= '0;
      npcout2     <= '0;
      aout2       <= '0;
      bout2       <= '0;
      imout2      <= '0;
      out_illegal <= 1'b0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      irout2      <= inst_in2;
      npcout2     <= npc_in2;
      aout2       <= a_next;
      bout2       <= b_next;
      imout2      <= imm_next;
      out_illegal <= dec.illegal;
    end else if (advance) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dlx_decode_stage.sv
// tb/tb_dlx_decode_stage.sv - directed self-checking bench for dlx_decode_stage
module tb_dlx_decode_stage;

  logic        clock2 = 1'b0;
  logic        reset2;
  logic [31:0] inst_in2, npc_in2;
  logic        in_valid, in_ready;
  logic        reg_write_en;
  logic [4:0]  reg_add_in;
  logic [31:0] reg_data_in;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        ex_ready;
  logic        out_valid;
  logic [31:0] irout2, npcout2, aout2, bout2, imout2;
  logic        out_illegal;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] dbg_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] sw_inst, ori_inst, j_inst;

  always #5 clock2 = ~clock2;

  dlx_decode_stage dut (
    .clock2(clock2), .reset2(reset2), .inst_in2(inst_in2), .npc_in2(npc_in2),
    .in_valid(in_valid), .in_ready(in_ready), .reg_write_en(reg_write_en),
    .reg_add_in(reg_add_in), .reg_data_in(reg_data_in), .ex_load_valid(ex_load_valid),
    .ex_load_rd(ex_load_rd), .ex_ready(ex_ready), .out_valid(out_valid), .irout2(irout2),
    .npcout2(npcout2), .aout2(aout2), .bout2(bout2), .imout2(imout2),
    .out_illegal(out_illegal), .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock2);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [15:0] imm);
    return {op, rs1, rd, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] rd, input logic [5:0] func);
    return {6'h00, rs1, rs2, rd, 5'd0, func};
  endfunction

  initial begin
    reset2 = 1'b0; inst_in2 = '0; npc_in2 = '0; in_valid = 1'b0;
    reg_write_en = 1'b0; reg_add_in = '0; reg_data_in = '0;
    ex_load_valid = 1'b0; ex_load_rd = '0; ex_ready = 1'b1; dbg_rd_addr = '0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_irout", irout2, 32'd0);
    check("rst_aout", aout2, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #1 reset2 = 1'b1;

    // Write-back R3, R2 and an attempted R0 write
    step();
    reg_write_en = 1'b1; reg_add_in = 5'd3; reg_data_in = 32'hFFFF_FFF6;
    step();
    reg_add_in = 5'd2; reg_data_in = 32'hA5A5_0002;
    step();
    reg_add_in = 5'd0; reg_data_in = 32'h0000_0055;
    step();
    reg_write_en = 1'b0;
    dbg_rd_addr = 5'd3; #1 check("dbg_r3", dbg_rd_data, 32'hFFFF_FFF6);
    dbg_rd_addr = 5'd2; #1 check("dbg_r2", dbg_rd_data, 32'hA5A5_0002);
    dbg_rd_addr = 5'd0; #1 check("dbg_r0", dbg_rd_data, 32'd0);

    // ADDI rs1=3 imm=FFFE
    inst_in2 = enc_i(6'h04, 5'd3, 5'd4, 16'hFFFE); npc_in2 = 32'h0000_0104; in_valid = 1'b1;
    step();
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_a", aout2, 32'hFFFF_FFF6);
    check("addi_imm", imout2, 32'hFFFF_FFFE);
    check("addi_b", bout2, 32'd0);
    check("addi_npc", npcout2, 32'h0000_0104);

    // Bypass: write R5 while decoding ADD rs1=5, rs2=0
    reg_write_en = 1'b1; reg_add_in = 5'd5; reg_data_in = 32'h0000_1234;
    inst_in2 = enc_r(5'd5, 5'd0, 5'd6, 6'h20);
    step();
    reg_write_en = 1'b0;
    check("add_a_bypass", aout2, 32'h0000_1234);
    check("add_b", bout2, 32'd0);
    check("add_imm", imout2, 32'd0);
    check("add_illegal", {31'd0, out_illegal}, 32'd0);

    // Load-use hazard on rs1 of SW
    sw_inst = enc_i(6'h03, 5'd7, 5'd2, 16'h0010);
    ex_load_valid = 1'b1; ex_load_rd = 5'd7; inst_in2 = sw_inst;
    #1 check("haz_rs1_ready", {31'd0, in_ready}, 32'd0);
    ex_load_rd = 5'd2;
    #1 check("haz_rs2_ready", {31'd0, in_ready}, 32'd0);
    ex_load_rd = 5'd7;
    step();
    check("haz_bubble", {31'd0, out_valid}, 32'd0);
    ex_load_valid = 1'b0;
    #1 check("haz_clear_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("sw_valid", {31'd0, out_valid}, 32'd1);
    check("sw_ir", irout2, sw_inst);
    check("sw_b", bout2, 32'hA5A5_0002);
    check("sw_imm", imout2, 32'h0000_0010);

    // ADDI rd=7 does not read rd, so a load into R7 must not stall it
    ex_load_valid = 1'b1; ex_load_rd = 5'd7;
    inst_in2 = enc_i(6'h04, 5'd1, 5'd7, 16'h0001);
    #1 check("no_haz_rd", {31'd0, in_ready}, 32'd1);
    ex_load_valid = 1'b0;

    // Stall three cycles with ORI offered, then release
    ori_inst = enc_i(6'h07, 5'd0, 5'd1, 16'h8001);
    inst_in2 = ori_inst; ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_ready", {31'd0, in_ready}, 32'd0);
      step();
      check("stall_ir", irout2, sw_inst);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    ex_ready = 1'b1;
    #1 check("release_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("ori_ir", irout2, ori_inst);
    check("ori_imm", imout2, 32'h0000_8001);

    // J with negative offset
    j_inst = {6'h11, 26'h3FFFFFC};
    inst_in2 = j_inst;
    step();
    check("j_imm", imout2, 32'hFFFF_FFFC);
    check("j_a", aout2, 32'd0);

    // Illegal opcode and illegal R-type func
    inst_in2 = {6'b111111, 5'd3, 5'd2, 16'h1234};
    step();
    check("ill_op", {31'd0, out_illegal}, 32'd1);
    check("ill_op_a", aout2, 32'd0);
    check("ill_op_imm", imout2, 32'd0);
    inst_in2 = enc_r(5'd3, 5'd2, 5'd1, 6'h3F);
    step();
    check("ill_fn", {31'd0, out_illegal}, 32'd1);
    check("ill_fn_b", bout2, 32'd0);

    // Bubble, then stall on ANDI and reset mid-stall
    in_valid = 1'b0;
    step();
    check("idle_bubble", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; inst_in2 = enc_i(6'h06, 5'd3, 5'd1, 16'hF0F0);
    step();
    check("andi_imm", imout2, 32'h0000_F0F0);
    ex_ready = 1'b0;
    step();
    check("andi_held", {31'd0, out_valid}, 32'd1);
    #2 reset2 = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ir", irout2, 32'd0);
    check("mid_rst_a", aout2, 32'd0);
    check("mid_rst_imm", imout2, 32'd0);
    for (int r = 0; r < 32; r++) begin
      dbg_rd_addr = 5'(r);
      #1 check("mid_rst_dbg", dbg_rd_data, 32'd0);
    end
    reset2 = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
